// File: rtl/pong_match_ctrl.sv
// Match controller for the pong ball/paddle engine: start, serve pause, BCD
// countdown, scoring, win/timeout detection and winner reporting.
module pong_match_ctrl #(
  parameter int TICKS_PER_SEC = 25000000,
  parameter int GAME_SECONDS  = 60,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_SECONDS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       stop,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SERVE_SECONDS > 1) ? $clog2(SERVE_SECONDS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_SECONDS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [3:0]    SEC1_INIT  = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]    SEC0_INIT  = 4'(GAME_SECONDS % 10);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0]    r_state, w_state_n;
  logic [PW-1:0] r_presc, w_presc_n;
  logic [SW-1:0] r_serve_cnt, w_serve_n;
  logic [3:0]    r_sec1, r_sec0, w_sec1_n, w_sec0_n;
  logic [3:0]    r_score1, r_score2, w_score1_n, w_score2_n;
  logic [1:0]    r_winner, w_winner_n;
  logic          r_stop, r_game_over;
  logic          r_start_d, r_miss1_d, r_miss2_d;
  logic          w_start_p, w_miss1_p, w_miss2_p, w_tick;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  always_comb begin
    w_start_p  = start & ~r_start_d;
    w_miss1_p  = miss1 & ~r_miss1_d;
    w_miss2_p  = miss2 & ~r_miss2_d;
    w_tick     = (r_presc == PRESC_MAX);
    w_state_n  = r_state;
    w_presc_n  = r_presc;
    w_serve_n  = r_serve_cnt;
    w_sec1_n   = r_sec1;
    w_sec0_n   = r_sec0;
    w_score1_n = r_score1;
    w_score2_n = r_score2;
    w_winner_n = r_winner;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_p) begin
          w_state_n  = S_SERVE;
          w_score1_n = 4'd0;
          w_score2_n = 4'd0;
          w_sec1_n   = SEC1_INIT;
          w_sec0_n   = SEC0_INIT;
          w_winner_n = 2'b00;
        end
      end
      S_SERVE: begin
        w_presc_n = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          if (r_serve_cnt == SERVE_LAST) begin
            w_serve_n = '0;
            w_state_n = S_PLAY;
          end else begin
            w_serve_n = r_serve_cnt + SW'(1);
          end
        end
      end
      default: begin
        w_presc_n = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick && (r_sec1 != 4'd0 || r_sec0 != 4'd0)) begin
          if (r_sec0 == 4'd0) begin
            w_sec0_n = 4'd9;
            w_sec1_n = r_sec1 - 4'd1;
          end else begin
            w_sec0_n = r_sec0 - 4'd1;
          end
        end
        if (w_miss1_p) w_score2_n = sat_inc(r_score2);
        if (w_miss2_p) w_score1_n = sat_inc(r_score1);
        if (w_miss1_p | w_miss2_p)
          w_state_n = (w_score1_n == WIN || w_score2_n == WIN) ? S_OVER : S_SERVE;
        // Timeout overrides the serve return; scores above are already applied.
        if (w_tick && w_sec1_n == 4'd0 && w_sec0_n == 4'd0)
          w_state_n = S_OVER;
        if (w_state_n == S_OVER) begin
          if (w_score1_n > w_score2_n)      w_winner_n = 2'b01;
          else if (w_score2_n > w_score1_n) w_winner_n = 2'b10;
          else                              w_winner_n = 2'b11;
        end
      end
    endcase
    if (w_state_n != r_state) w_presc_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_serve_cnt <= '0;
      r_sec1      <= SEC1_INIT;
      r_sec0      <= SEC0_INIT;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_winner    <= 2'b00;
      r_stop      <= 1'b1;
      r_game_over <= 1'b0;
      r_start_d   <= 1'b0;
      r_miss1_d   <= 1'b0;
      r_miss2_d   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_presc     <= w_presc_n;
      r_serve_cnt <= w_serve_n;
      r_sec1      <= w_sec1_n;
      r_sec0      <= w_sec0_n;
      r_score1    <= w_score1_n;
      r_score2    <= w_score2_n;
      r_winner    <= w_winner_n;
      r_stop      <= (w_state_n != S_PLAY);
      r_game_over <= (w_state_n == S_OVER);
      r_start_d   <= start;
      r_miss1_d   <= miss1;
      r_miss2_d   <= miss2;
    end
  end

  assign stop      = r_stop;
  assign sec1      = r_sec1;
  assign sec0      = r_sec0;
  assign score1    = r_score1;
  assign score2    = r_score2;
  assign game_over = r_game_over;
  assign winner    = r_winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus random play,
// compared every cycle against a seconds/phase-level model of the match.
module tb_pong_match_ctrl;
  localparam int TICKS = 4;
  localparam int GAME  = 12;
  localparam int WINS  = 3;
  localparam int SERVS = 1;

  localparam int MS_IDLE  = 0;
  localparam int MS_SERVE = 1;
  localparam int MS_PLAY  = 2;
  localparam int MS_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, miss1 = 1'b0, miss2 = 1'b0;
  logic       stop, game_over;
  logic [3:0] sec1, sec0, score1, score2;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  pong_match_ctrl #(
    .TICKS_PER_SEC(TICKS), .GAME_SECONDS(GAME),
    .WIN_SCORE(WINS), .SERVE_SECONDS(SERVS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
    .stop(stop), .sec1(sec1), .sec0(sec0), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: state, cycles since entering it, whole seconds left, scores.
  int m_state = MS_IDLE, m_phase = 0, m_t = GAME, m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_pst = 1'b0, m_pm1 = 1'b0, m_pm2 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= MS_IDLE; m_phase <= 0; m_t <= GAME;
      m_s1 <= 0; m_s2 <= 0; m_win <= 0;
      m_pst <= 1'b0; m_pm1 <= 1'b0; m_pm2 <= 1'b0;
    end else begin
      int ns, nt, n1, n2, nw;
      bit sp, p1, p2;
      sp = start & ~m_pst;
      p1 = miss1 & ~m_pm1;
      p2 = miss2 & ~m_pm2;
      ns = m_state; nt = m_t; n1 = m_s1; n2 = m_s2; nw = m_win;
      if (m_state == MS_IDLE || m_state == MS_OVER) begin
        if (sp) begin
          ns = MS_SERVE; n1 = 0; n2 = 0; nt = GAME; nw = 0;
        end
      end else if (m_state == MS_SERVE) begin
        if (m_phase == TICKS * SERVS - 1) ns = MS_PLAY;
      end else begin
        if ((m_phase % TICKS) == TICKS - 1 && m_t > 0) nt = m_t - 1;
        if (p1) n2 = (m_s2 + 1 > WINS) ? WINS : m_s2 + 1;
        if (p2) n1 = (m_s1 + 1 > WINS) ? WINS : m_s1 + 1;
        if (p1 || p2) ns = (n1 == WINS || n2 == WINS) ? MS_OVER : MS_SERVE;
        if (nt == 0) ns = MS_OVER;
        if (ns == MS_OVER) nw = (n1 > n2) ? 1 : (n2 > n1) ? 2 : 3;
      end
      m_phase <= (ns != m_state) ? 0 : m_phase + 1;
      m_state <= ns; m_t <= nt; m_s1 <= n1; m_s2 <= n2; m_win <= nw;
      m_pst <= start; m_pm1 <= miss1; m_pm2 <= miss2;
    end
  end

  always @(negedge clk) begin
    check("stop",      int'(stop),      int'(m_state != MS_PLAY));
    check("game_over", int'(game_over), int'(m_state == MS_OVER));
    check("sec1",      int'(sec1),      m_t / 10);
    check("sec0",      int'(sec0),      m_t % 10);
    check("score1",    int'(score1),    m_s1);
    check("score2",    int'(score2),    m_s2);
    check("winner",    int'(winner),    m_win);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_miss(input logic a, input logic b);
    miss1 = a; miss2 = b;
    cycles(1);
    miss1 = 1'b0; miss2 = 1'b0;
  endtask

  task automatic wait_play();
    int n = 0;
    while (stop && n < 100) begin
      cycles(1);
      n++;
    end
    if (stop) check("wait_play_timeout", int'(stop), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Idle then start; stop falls 4 cycles after the start edge.
    cycles(50);
    check("idle_stop", int'(stop), 1);
    check("idle_sec1", int'(sec1), 1);
    check("idle_sec0", int'(sec0), 2);
    check("idle_scores", int'(score1) + int'(score2), 0);
    check("idle_game_over", int'(game_over), 0);
    check("model_idle_t", m_t, 12);
    pulse_start();
    cycles(3);
    check("serve_stop_hold", int'(stop), 1);
    cycles(1);
    check("serve_stop_fall", int'(stop), 0);
    cycles(8);
    check("play8_sec1", int'(sec1), 1);
    check("play8_sec0", int'(sec0), 0);
    cycles(4);
    check("borrow_sec1", int'(sec1), 0);
    check("borrow_sec0", int'(sec0), 9);
    check("model_borrow_t", m_t, 9);

    // miss1 held for 10 cycles scores once.
    miss1 = 1'b1;
    cycles(1);
    check("miss1_score2", int'(score2), 1);
    check("miss1_stop", int'(stop), 1);
    cycles(3);
    check("miss1_serve_hold", int'(stop), 1);
    cycles(1);
    check("miss1_replay", int'(stop), 0);
    cycles(5);
    miss1 = 1'b0;
    check("miss1_once", int'(score2), 1);

    // Simultaneous misses.
    do_reset(); pulse_start(); wait_play();
    pulse_miss(1'b1, 1'b1);
    check("both_score1", int'(score1), 1);
    check("both_score2", int'(score2), 1);
    check("both_serve", int'(stop), 1);
    check("both_not_over", int'(game_over), 0);

    // Three miss2 edges win for player 1.
    do_reset(); pulse_start(); wait_play();
    for (int k = 0; k < 3; k++) begin
      pulse_miss(1'b0, 1'b1);
      if (k < 2) wait_play();
    end
    check("win_score1", int'(score1), 3);
    check("win_over", int'(game_over), 1);
    check("win_winner", int'(winner), 1);
    cycles(10);
    check("win_freeze_sec1", int'(sec1), 1);
    check("win_freeze_sec0", int'(sec0), 2);

    // Timeout with no misses is a tie.
    do_reset(); pulse_start();
    begin
      int n = 0;
      while (!game_over && n < 300) begin
        cycles(1);
        n++;
      end
    end
    check("tout_over", int'(game_over), 1);
    check("tout_sec1", int'(sec1), 0);
    check("tout_sec0", int'(sec0), 0);
    check("tout_winner", int'(winner), 3);
    pulse_start();
    check("restart_scores", int'(score1) + int'(score2), 0);
    check("restart_sec1", int'(sec1), 1);
    check("restart_sec0", int'(sec0), 2);
    check("restart_stop", int'(stop), 1);
    check("restart_over", int'(game_over), 0);
    check("restart_winner", int'(winner), 0);

    // Asynchronous reset mid-play with score1=2.
    do_reset(); pulse_start(); wait_play();
    pulse_miss(1'b0, 1'b1); wait_play();
    pulse_miss(1'b0, 1'b1); wait_play();
    check("pre_rst_score1", int'(score1), 2);
    miss1 = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_stop", int'(stop), 1);
    check("arst_score1", int'(score1), 0);
    check("arst_sec1", int'(sec1), 1);
    check("arst_sec0", int'(sec0), 2);
    check("arst_over", int'(game_over), 0);
    check("arst_winner", int'(winner), 0);
    cycles(1);
    rst = 1'b0;
    cycles(3);
    check("post_rst_score2", int'(score2), 0);
    check("post_rst_idle", int'(stop), 1);
    miss1 = 1'b0;

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) miss1 = ~miss1;
      if ($urandom_range(0, 7) == 0) miss2 = ~miss2;
      rst = ($urandom_range(0, 999) == 0);
      cycles(1);
    end
    rst = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match controller that sits directly upstream and downstream of the paddle/ball state machine.
- Consumes its miss1/miss2 outputs; drives its stop and sec1 inputs.
- Runs the match: start, serve pause, BCD countdown timer, scoring, win/timeout, winner.
- Its score and timer outputs also feed the on-screen digit renderer.

Parameters:
- TICKS_PER_SEC, 25000000: clk cycles per game second (25 MHz pixel clock).
- GAME_SECONDS, 60: match length in seconds; legal range 1..99.
- WIN_SCORE, 9: score that ends the match immediately; legal range 1..9.
- SERVE_SECONDS, 2: stop-hold duration before each serve; must be 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  start button, synchronous level; acted on at its rising edge
- miss1  in  1  player 1 missed, level from ball state machine
- miss2  in  1  player 2 missed, level from ball state machine
- stop  out  1  freezes and recentres ball and paddles when high
- sec1  out  4  BCD tens digit of remaining time
- sec0  out  4  BCD units digit of remaining time
- score1  out  4  player 1 score, binary 0..WIN_SCORE
- score2  out  4  player 2 score, binary 0..WIN_SCORE
- game_over  out  1  high in OVER state
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie; valid when game_over=1

Behaviour:
- Reset (async, any time, including mid-match) forces:
  - state IDLE, stop=1, game_over=0, winner=00
  - score1=score2=0
  - sec1:sec0 = BCD(GAME_SECONDS)
  - prescaler=0, serve counter=0
  - edge-detect registers cleared
- All outputs are registered.
- Edge detect:
  - start_p = start & ~start_r; miss1_p and miss2_p formed the same way.
  - The history registers update every cycle in every state.
  - Edges on cycles where they are not consumed are discarded, not queued.
- Prescaler: counts 0..TICKS_PER_SEC-1; sec_tick is a one-cycle pulse on the wrap. Cleared to 0 on every state entry.
- States:
  - IDLE: stop=1. start_p -> SERVE; scores cleared, timer reloaded, winner=00.
  - SERVE: stop=1; timer frozen; prescaler runs.
    - Serve counter increments on each sec_tick.
    - When it reaches SERVE_SECONDS -> PLAY and serve counter clears. With SERVE_SECONDS=1 this is exactly TICKS_PER_SEC cycles after entry.
    - Miss edges are ignored.
  - PLAY: stop=0; prescaler runs; each sec_tick decrements sec1:sec0 as BCD (x0 -> (x-1)9).
    - Miss scoring: miss1_p adds 1 to score2; miss2_p adds 1 to score1. Both in the same cycle add to both.
    - After any miss edge: if either updated score equals WIN_SCORE -> OVER, otherwise -> SERVE.
    - Timeout: a decrement reaching 00 -> OVER; the display shows 00.
    - Same-cycle miss edge and final tick: the score is applied first, then the state goes to OVER, winner decided from updated scores.
    - start is ignored.
  - OVER: stop=1; game_over=1; timer and scores held.
    - winner set on entry: larger score wins; equal scores give 11.
    - start_p -> SERVE with scores cleared, timer reloaded, game_over=0, winner=00.
- Scores saturate at WIN_SCORE (unreachable in practice, since OVER is taken first).
- The timer never wraps below 00.
- stop is high in every state except PLAY, and is low in exactly the cycles spent in PLAY.

Test Plan:
All scenarios use TICKS_PER_SEC=4, GAME_SECONDS=12, WIN_SCORE=3, SERVE_SECONDS=1.
- Reset then idle 50 cycles -> stop=1, sec1=1, sec0=2, scores 0, game_over=0. Pulse start -> SERVE; stop falls exactly 4 cycles after the start edge is seen.
- Enter PLAY, wait 8 cycles -> timer shows 1,0. Wait 4 more -> 0,9 (BCD borrow). Hold miss1 high for 10 cycles -> score2=1 exactly once, stop=1 for one serve period.
- Raise miss1 and miss2 in the same PLAY cycle -> score1=1, score2=1; state SERVE.
- Drive three separate miss2 edges across serves -> score1=3, immediate OVER, winner=01, timer frozen at its current value.
- No misses until timeout -> sec1:sec0 reaches 0,0, game_over=1, winner=11. Then pulse start -> scores 0, timer 1,2, SERVE.
- Assert rst mid-PLAY with score1=2 -> all outputs return to reset values asynchronously; a pending miss edge after reset release does not score.
